shower_ctrl: RTL and testbench
==============================

# shower_ctrl

Sequencing controller for the per-BX shower detector. It takes the detector's 2-bit shower quality and merges consecutive hits over a programmable collection window into a single result carrying the best quality and the BX of the first hit. It presents that result to the DAQ/trigger link over a valid/ack handshake, and drives the detector's trig_stop input during presentation and holdoff. It sits between the shower detector output and the ALCT trigger link, and owns the local BX counter used to tag results.

## Interface
Parameters:
- BX_MAX, 3563: last BX value before the counter wraps to 0.
- LOST_W, 8: width of the saturating lost-shower counter.

Ports:
- clk  in  1  system clock, 40 MHz (one BX per cycle).
- rst_n  in  1  reset; asynchronous assert, active-low.
- shower_int  in  2  detector quality: 0 none, 1 loose, 2 nominal, 3 tight.
- enable  in  1  accepts new showers when high.
- window_len  in  3  collection window length in cycles (0 means no collection).
- holdoff_len  in  4  post-ack holdoff length in cycles (0 means none).
- bc0  in  1  bunch-crossing-zero marker; resets the BX counter.
- lost_clr  in  1  synchronous clear of lost_cnt.
- trig_stop  out  1  to the detector; suppresses shower_int.
- shower_valid  out  1  result available.
- shower_out  out  2  result quality.
- shower_bx  out  12  BX of the first hit in the merged result.
- shower_ack  in  1  consumer accepts the result.
- lost_cnt  out  LOST_W  count of showers that arrived while busy.
- bx_cnt  out  12  current BX counter value.

## Operation
- FSM states are IDLE, COLLECT, PRESENT and HOLDOFF. A down-counter cnt (4 bit), best (2 bit) and first_bx (12 bit) are registers.
- IDLE:
  - If enable=1 and shower_int≠0, then best←shower_int and first_bx←bx_cnt.
  - Next state is COLLECT with cnt←window_len, or PRESENT if window_len=0.
- COLLECT:
  - best←max(best, shower_int).
  - If cnt≤1, go to PRESENT; otherwise cnt←cnt−1. COLLECT therefore lasts exactly window_len cycles.
  - If enable=0, discard the result and go to IDLE.
- PRESENT:
  - shower_valid=1, shower_out=best, shower_bx=first_bx, all held stable.
  - A transfer occurs on a cycle where shower_valid=1 and shower_ack=1.
  - On transfer, go to HOLDOFF with cnt←holdoff_len, or to IDLE if holdoff_len=0.
  - enable has no effect in this state.
- HOLDOFF: when cnt≤1 go to IDLE, otherwise cnt←cnt−1. enable has no effect in this state.
- trig_stop is 1 when the next state is PRESENT or HOLDOFF, or when enable=0.
- Lost showers:
  - lost_cnt increments on any cycle in PRESENT or HOLDOFF with shower_int≠0.
  - It saturates at 2^LOST_W−1.
  - lost_clr has priority over increment; clear and increment in the same cycle leaves 0.
- BX counter:
  - bx_cnt increments every cycle and wraps from BX_MAX to 0.
  - bc0=1 loads 0 on the next edge, overriding the increment.
  - first_bx samples the pre-edge value of bx_cnt.
- Reset values: state=IDLE, trig_stop=0, shower_valid=0, shower_out=0, shower_bx=0, lost_cnt=0, bx_cnt=0, best=0, cnt=0.
- A reset mid-operation aborts any pending result with no handshake.

## Timing
- All outputs are registered.
- A first hit at edge n gives shower_valid=1 after edge n+window_len+1, and trig_stop rises at the same time.
- A transfer at edge t:
  - shower_valid=0 after edge t.
  - trig_stop remains 1 for holdoff_len further cycles, then falls.
  - With holdoff_len=0, trig_stop falls after edge t.
- The detector gates with a one-cycle pipeline. A shower_int≠0 arriving in the first PRESENT cycle is counted as lost, by design.
- shower_ack while shower_valid=0 is ignored.

## Structure
- shower_ctrl_pkg holds:
  - the state enum;
  - the quality constants Q_NONE=0, Q_LOOSE=1, Q_NOMINAL=2, Q_TIGHT=3;
  - BX_W=12 and the BX_MAX default.
- One sub-module, shower_bx_cnt, contains the wrapping BX counter with bc0 load. It is reused by other trigger blocks.

## Test plan
- window_len=3, holdoff_len=2; shower_int 1,0,3,2 from BX 100; ack one cycle after valid → single result shower_out=3, shower_bx=100; trig_stop high for 1 PRESENT cycle + 2 HOLDOFF cycles.
- window_len=0, holdoff_len=0; shower_int=2 at BX 7; hold ack low for 5 cycles → valid, shower_out and shower_bx=7 stable for all 5 cycles; shower_int=1 pulses during the wait → lost_cnt=5 (with pulses every cycle).
- Drive bx to 3563, then apply a hit → shower_bx=3563; the next bx_cnt value is 0. Assert bc0 at bx=50 → bx_cnt=0 on the next cycle.
- Drop enable during COLLECT → no shower_valid; trig_stop=1 while enable=0; state returns to IDLE.
- Keep shower_int=3 constantly in HOLDOFF for 300 cycles → lost_cnt saturates at 255; lost_clr in the same cycle as a hit → 0.
- Assert rst_n=0 asynchronously while in PRESENT → shower_valid and trig_stop drop immediately; no transfer occurs after release.

Source files
------------

// File: rtl/shower_ctrl_pkg.sv
// shower_ctrl_pkg: shared types and constants for the shower sequencing controller
package shower_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, PRESENT, HOLDOFF} state_t;
    localparam logic [1:0] Q_NONE    = 2'd0;
    localparam logic [1:0] Q_LOOSE   = 2'd1;
    localparam logic [1:0] Q_NOMINAL = 2'd2;
    localparam logic [1:0] Q_TIGHT   = 2'd3;
    localparam int BX_W       = 12;
    localparam int BX_MAX_DEF = 3563;
endpackage

// File: rtl/shower_bx_cnt.sv
// shower_bx_cnt: wrapping bunch-crossing counter, bc0 forces it back to zero
module shower_bx_cnt
    import shower_ctrl_pkg::*;
#(
    parameter int BX_MAX = BX_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bc0,
    output logic [BX_W-1:0] bx_cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bx_cnt <= '0;
        else if (bc0) bx_cnt <= '0;
        else bx_cnt <= (bx_cnt == BX_W'(BX_MAX)) ? '0 : bx_cnt + 1'b1;
    end
endmodule

// File: rtl/shower_ctrl.sv
// shower_ctrl: merges shower hits over a window, presents the result over valid/ack,
// and throttles the detector with trig_stop while busy.
module shower_ctrl
    import shower_ctrl_pkg::*;
#(
    parameter int BX_MAX = BX_MAX_DEF,
    parameter int LOST_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        shower_int,
    input  logic              enable,
    input  logic [2:0]        window_len,
    input  logic [3:0]        holdoff_len,
    input  logic              bc0,
    input  logic              lost_clr,
    output logic              trig_stop,
    output logic              shower_valid,
    output logic [1:0]        shower_out,
    output logic [BX_W-1:0]   shower_bx,
    input  logic              shower_ack,
    output logic [LOST_W-1:0] lost_cnt,
    output logic [BX_W-1:0]   bx_cnt
);
    state_t          state, nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [1:0]      best, best_nxt;
    logic [BX_W-1:0] first_bx, fbx_nxt;
    logic            busy;

    shower_bx_cnt #(.BX_MAX(BX_MAX)) u_bx (.clk(clk), .rst_n(rst_n), .bc0(bc0), .bx_cnt(bx_cnt));

    assign busy = (state == PRESENT) || (state == HOLDOFF);

    always_comb begin
        nxt      = state;
        cnt_nxt  = cnt;
        best_nxt = best;
        fbx_nxt  = first_bx;
        case (state)
            IDLE: if (enable && shower_int != Q_NONE) begin
                best_nxt = shower_int;
                fbx_nxt  = bx_cnt;
                cnt_nxt  = {1'b0, window_len};
                nxt      = (window_len == 3'd0) ? PRESENT : COLLECT;
            end
            COLLECT: if (!enable) begin
                nxt = IDLE;
            end else begin
                best_nxt = (shower_int > best) ? shower_int : best;
                if (cnt <= 4'd1) nxt = PRESENT;
                else cnt_nxt = cnt - 4'd1;
            end
            PRESENT: if (shower_valid && shower_ack) begin
                cnt_nxt = holdoff_len;
                nxt     = (holdoff_len == 4'd0) ? IDLE : HOLDOFF;
            end
            HOLDOFF: if (cnt <= 4'd1) nxt = IDLE;
                else cnt_nxt = cnt - 4'd1;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            best         <= Q_NONE;
            first_bx     <= '0;
            trig_stop    <= 1'b0;
            shower_valid <= 1'b0;
            shower_out   <= Q_NONE;
            shower_bx    <= '0;
            lost_cnt     <= '0;
        end else begin
            state        <= nxt;
            cnt          <= cnt_nxt;
            best         <= best_nxt;
            first_bx     <= fbx_nxt;
            trig_stop    <= (nxt == PRESENT) || (nxt == HOLDOFF) || !enable;
            shower_valid <= (nxt == PRESENT);
            shower_out   <= (nxt == PRESENT) ? best_nxt : Q_NONE;
            shower_bx    <= (nxt == PRESENT) ? fbx_nxt : '0;
            if (lost_clr) lost_cnt <= '0;
            else if (busy && shower_int != Q_NONE && lost_cnt != {LOST_W{1'b1}}) lost_cnt <= lost_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_shower_ctrl.sv
// tb_shower_ctrl: scoreboard bench; transactions push expected results, a monitor checks them.
module tb_shower_ctrl;
    localparam int BXM = 3563;
    typedef struct {int q; int bx;} exp_t;

    logic        clk, rst_n, enable, bc0, lost_clr, shower_ack;
    logic [1:0]  shower_int;
    logic [2:0]  window_len;
    logic [3:0]  holdoff_len;
    logic        trig_stop, shower_valid;
    logic [1:0]  shower_out;
    logic [11:0] shower_bx, bx_cnt;
    logic [7:0]  lost_cnt;

    int   n_pass = 0, n_total = 0;
    int   ref_bx, ref_lost = 0, clr_at = -1;
    int   plan[$];
    exp_t exp_q[$];
    exp_t cur;
    bit   in_pres = 0, have = 0;

    shower_ctrl dut (
        .clk(clk), .rst_n(rst_n), .shower_int(shower_int), .enable(enable),
        .window_len(window_len), .holdoff_len(holdoff_len), .bc0(bc0), .lost_clr(lost_clr),
        .trig_stop(trig_stop), .shower_valid(shower_valid), .shower_out(shower_out),
        .shower_bx(shower_bx), .shower_ack(shower_ack), .lost_cnt(lost_cnt), .bx_cnt(bx_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) ref_bx <= 0;
        else ref_bx <= bc0 ? 0 : (ref_bx + 1) % (BXM + 1);

    always @(negedge clk) begin
        if (!rst_n) begin
            in_pres = 0;
        end else begin
            chk("bx_cnt", int'(bx_cnt), ref_bx);
            if (shower_valid) begin
                if (!in_pres) begin
                    chk("sb_nonempty", int'(exp_q.size() > 0), 1);
                    have = exp_q.size() > 0;
                    if (have) cur = exp_q.pop_front();
                    in_pres = 1;
                end
                if (have) begin
                    chk("shower_out", int'(shower_out), cur.q);
                    chk("shower_bx", int'(shower_bx), cur.bx);
                end
            end else in_pres = 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int nxt_q(input bit first);
        if (plan.size() > 0) return plan.pop_front();
        return first ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
    endfunction

    function automatic int sat(input int v);
        return v > 255 ? 255 : v;
    endfunction

    task automatic wait_bx(input int t);
        for (int i = 0; i < 4000 && ref_bx != t; i++) tick;
        chk("bx_reach", int'(bx_cnt), t);
    endtask

    task automatic clr_lost;
        lost_clr = 1;
        tick;
        lost_clr = 0;
        ref_lost = 0;
        chk("lost_cleared", int'(lost_cnt), 0);
    endtask

    // One full hit -> present -> ack -> holdoff sequence; w quals merged, d cycles of ack delay.
    task automatic txn(input int w, input int h, input int d);
        int   q;
        exp_t e;
        enable = 1; window_len = 3'(w); holdoff_len = 4'(h);
        q = nxt_q(1);
        e.q = q; e.bx = ref_bx;
        shower_int = 2'(q);
        for (int i = 0; i < w; i++) begin
            tick;
            q = nxt_q(0);
            shower_int = 2'(q);
            if (q > e.q) e.q = q;
        end
        exp_q.push_back(e);
        tick;
        chk("valid_rise", int'(shower_valid), 1);
        chk("trig_rise", int'(trig_stop), 1);
        for (int j = 0; j <= d; j++) begin
            q = nxt_q(0);
            shower_int = 2'(q);
            shower_ack = (j == d);
            lost_clr = (j == clr_at);
            ref_lost = (j == clr_at) ? 0 : sat(ref_lost + int'(q != 0));
            tick;
            if (j == clr_at) chk("lost_clr_hit", int'(lost_cnt), 0);
        end
        shower_ack = 0; lost_clr = 0;
        for (int k = 0; k < h; k++) begin
            chk("trig_hold", int'(trig_stop), 1);
            chk("valid_off", int'(shower_valid), 0);
            q = nxt_q(0);
            shower_int = 2'(q);
            ref_lost = sat(ref_lost + int'(q != 0));
            tick;
        end
        shower_int = 0;
        chk("trig_fall", int'(trig_stop), 0);
        chk("valid_fall", int'(shower_valid), 0);
        chk("lost_cnt", int'(lost_cnt), ref_lost);
    endtask

    initial begin
        rst_n = 0; enable = 0; bc0 = 0; lost_clr = 0; shower_ack = 0;
        shower_int = 0; window_len = 0; holdoff_len = 0;
        #2;
        chk("rst_valid", int'(shower_valid), 0);
        chk("rst_trig", int'(trig_stop), 0);
        chk("rst_out", int'(shower_out), 0);
        chk("rst_bx", int'(shower_bx), 0);
        chk("rst_lost", int'(lost_cnt), 0);
        chk("rst_bxcnt", int'(bx_cnt), 0);
        enable = 1;
        #1 rst_n = 1;
        tick;
        wait_bx(50);
        bc0 = 1;
        tick;
        bc0 = 0;
        chk("bc0_load", int'(bx_cnt), 0);
        // zero-window presentation held for five cycles with busy-time pulses
        wait_bx(7);
        plan = '{2, 1, 1, 1, 1, 1, 0};
        txn(0, 0, 5);
        chk("lost_five", int'(lost_cnt), 5);
        clr_lost;
        // merged window of qualities 1,0,3,2 starting at BX 100
        wait_bx(100);
        plan = '{1, 0, 3, 2, 0, 0, 0, 0};
        txn(3, 2, 1);
        // hit on the last BX before wrap
        wait_bx(BXM);
        txn(2, 1, 0);
        // saturation of the lost counter
        plan = {};
        for (int i = 0; i < 301; i++) plan.push_back(3);
        txn(0, 0, 299);
        chk("lost_sat", int'(lost_cnt), 255);
        plan = '{3, 3, 3, 3, 3, 3};
        clr_at = 1;
        txn(1, 1, 2);
        clr_at = -1;
        // enable dropped mid-collection discards the result
        enable = 1; window_len = 3'd4; holdoff_len = 4'd0; shower_int = 2;
        tick;
        shower_int = 1;
        tick;
        enable = 0; shower_int = 3;
        tick;
        chk("drop_trig", int'(trig_stop), 1);
        chk("drop_valid", int'(shower_valid), 0);
        for (int i = 0; i < 6; i++) tick;
        chk("drop_idle_valid", int'(shower_valid), 0);
        enable = 1; shower_int = 0;
        tick;
        chk("drop_trig_fall", int'(trig_stop), 0);
        chk("drop_lost", int'(lost_cnt), ref_lost);
        // randomized transactions
        for (int n = 0; n < 25; n++)
            txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        // asynchronous reset while presenting
        window_len = 0; holdoff_len = 0; shower_int = 3;
        tick;
        shower_int = 0;
        chk("pre_rst_valid", int'(shower_valid), 1);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", int'(shower_valid), 0);
        chk("arst_trig", int'(trig_stop), 0);
        ref_lost = 0;
        #3 rst_n = 1;
        shower_ack = 1;
        for (int i = 0; i < 5; i++) tick;
        shower_ack = 0;
        chk("post_rst_valid", int'(shower_valid), 0);
        chk("post_rst_lost", int'(lost_cnt), 0);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
